// File: rtl/controller_sequencer.sv
// Six-state ring-counter controller/sequencer driving a 12-bit control word.
// Define SINGLE_STEP_EN to add the STEP port; the ring and halt flag then move only on STEP=1 edges.
module controller_sequencer (
  input  logic        CLK,
  input  logic        CLR,
  input  logic [3:0]  I,
`ifdef SINGLE_STEP_EN
  input  logic        STEP,
`endif
  output logic [11:0] CON,
  output logic [5:0]  T,
  output logic        HLT
);

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } ring_t;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [11:0] W_NOP     = 12'h3E3;
  localparam logic [11:0] W_FETCH1  = 12'h5E3;
  localparam logic [11:0] W_FETCH2  = 12'hBE3;
  localparam logic [11:0] W_FETCH3  = 12'h263;
  localparam logic [11:0] W_ADDR    = 12'h1A3;
  localparam logic [11:0] W_LOAD_A  = 12'h2C3;
  localparam logic [11:0] W_LOAD_B  = 12'h2E1;
  localparam logic [11:0] W_ADD_A   = 12'h3C7;
  localparam logic [11:0] W_SUB_A   = 12'h3CF;
  localparam logic [11:0] W_OUT     = 12'h3F2;

  ring_t state, state_nxt;
  logic  hlt_nxt;
  logic  advance;

`ifdef SINGLE_STEP_EN
  assign advance = STEP;
`else
  assign advance = 1'b1;
`endif

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state <= T1;
      HLT   <= 1'b0;
    end else begin
      state <= state_nxt;
      HLT   <= hlt_nxt;
    end
  end

  // A halt opcode in T4 freezes the ring at T4 instead of advancing.
  always_comb begin
    state_nxt = state;
    hlt_nxt   = HLT;
    if (advance && !HLT) begin
      if (state == T4 && I == OP_HLT) begin
        hlt_nxt = 1'b1;
      end else begin
        case (state)
          T1:      state_nxt = T2;
          T2:      state_nxt = T3;
          T3:      state_nxt = T4;
          T4:      state_nxt = T5;
          T5:      state_nxt = T6;
          default: state_nxt = T1;
        endcase
      end
    end
  end

  assign T = state;

  always_comb begin
    CON = W_NOP;
    if (!HLT) begin
      case (state)
        T1: CON = W_FETCH1;
        T2: CON = W_FETCH2;
        T3: CON = W_FETCH3;
        T4: begin
          if (I == OP_LDA || I == OP_ADD || I == OP_SUB) CON = W_ADDR;
          else if (I == OP_OUT)                          CON = W_OUT;
        end
        T5: begin
          if (I == OP_LDA)                     CON = W_LOAD_A;
          else if (I == OP_ADD || I == OP_SUB) CON = W_LOAD_B;
        end
        T6: begin
          if (I == OP_ADD)      CON = W_ADD_A;
          else if (I == OP_SUB) CON = W_SUB_A;
        end
        default: CON = W_NOP;
      endcase
    end
  end

endmodule
